// File: rtl/main_ram_pkg.sv
// Shared types and helpers for the wait-state main RAM: FSM state encoding,
// wait-counter sizing and the per-byte write merge.
package main_ram_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS
   } state_t;

   localparam int WAIT_MAX   = 15;
   localparam int WAIT_CNT_W = 4;

   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/main_ram_array.sv
// Single-port synchronous word array with per-byte write enable and a
// registered read port (data appears the cycle after the address).
module main_ram_array
   import main_ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     q
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++)
            mem[addr][8*i +: 8] <= merge_byte(mem[addr][8*i +: 8], wdata[8*i +: 8], be[i]);
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/main_ram_ws.sv
// Main RAM with programmable wait states and optional zero-fill after reset.
// One access at a time: IDLE -> WAIT (WAIT_CYCLES cycles) -> ACCESS (ack).
module main_ram_ws
   import main_ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 14,
   parameter int WAIT_CYCLES    = 2,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   byteena,
   output logic                  ack,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy
);

   localparam int BE_W     = DATA_W / 8;
   localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_EFF > 0) ? WAIT_CNT_W'(WAIT_EFF - 1) : '0;

   state_t                  state, state_nxt;
   logic [ADDR_W-1:0]       clr_ptr;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic                    accept;

   logic                    we_cap;
   logic [ADDR_W-1:0]       addr_cap;
   logic [DATA_W-1:0]       wdata_cap;
   logic [BE_W-1:0]         be_cap;
   logic [DATA_W-1:0]       rdata_hold;

   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic [BE_W-1:0]         mem_be;
   logic [DATA_W-1:0]       mem_q;

   // Read address is presented on the edge entering ACCESS so the registered
   // array output is already valid during the ack cycle.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack       = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_cap;
      mem_wdata = wdata_cap;
      mem_be    = be_cap;
      case (state)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr;
            mem_wdata = '0;
            mem_be    = '1;
            if (clr_ptr == '1)
               state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            mem_addr = addr;
            if (req) begin
               accept = 1'b1;
               if (WAIT_EFF > 0)
                  state_nxt = ST_WAIT;
               else
                  state_nxt = ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == '0)
               state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            ack       = 1'b1;
            mem_we    = we_cap;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy  = (state == ST_CLEAR);
   assign rdata = (state == ST_ACCESS && !we_cap) ? mem_q : rdata_hold;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_ptr    <= '0;
         wait_cnt   <= '0;
         rdata_hold <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR)
            clr_ptr <= clr_ptr + 1'b1;
         if (accept)
            wait_cnt <= WAIT_LOAD;
         else if (state == ST_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
         if (ack && !we_cap)
            rdata_hold <= mem_q;
      end
   end

   // Request fields are frozen at acceptance; later input changes are ignored.
   always_ff @(posedge clock) begin
      if (accept) begin
         we_cap    <= we;
         addr_cap  <= addr;
         wdata_cap <= wdata;
         be_cap    <= byteena;
      end
   end

   main_ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clock  (clock),
      .we     (mem_we),
      .addr   (mem_addr),
      .wdata  (mem_wdata),
      .be     (mem_be),
      .q      (mem_q)
   );

endmodule
